// File: rtl/reg_write_bank_pkg.sv
// Shared constants for the register-file write bank: geometry, well-known register numbers, reset values.
package reg_write_bank_pkg;

    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned DATA_W   = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [ADDR_W-1:0] REG_GP   = 5'd28;
    localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
    localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

    localparam logic [DATA_W-1:0] SP_INIT_DEF = 32'h0000_03FC;
    localparam logic [DATA_W-1:0] GP_INIT_DEF = 32'h0000_0000;

endpackage

// File: rtl/reg_write_bank_dec5_32.sv
// Combinational 5-to-32 one-hot decoder with enable; all outputs low when i_en is low.
module dec5_32
    import reg_write_bank_pkg::*;
(
    input  logic                i_en,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [NUM_REGS-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            o_onehot[k] = i_en && (i_addr == ADDR_W'(k));
        end
    end

endmodule

// File: rtl/reg_write_bank.sv
// Write side of the 32x32 register file: decoded write-back into per-register flops, hardwired-zero r0,
// and a registered commit record (ack pulse, last address/data, write counter).
module reg_write_bank
    import reg_write_bank_pkg::*;
#(
    parameter int unsigned       WIDTH   = 32,
    parameter logic [WIDTH-1:0]  SP_INIT = WIDTH'(SP_INIT_DEF),
    parameter logic [WIDTH-1:0]  GP_INIT = WIDTH'(GP_INIT_DEF)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_we,
    input  logic [ADDR_W-1:0]         i_waddr,
    input  logic [WIDTH-1:0]          i_wdata,
    output logic [NUM_REGS*WIDTH-1:0] o_regs,
    output logic                      o_wr_ack,
    output logic [ADDR_W-1:0]         o_last_waddr,
    output logic [WIDTH-1:0]          o_last_wdata,
    output logic [15:0]               o_wr_count
);

    localparam int unsigned CNT_W = 16;

    logic [NUM_REGS-1:0] w_onehot;
    logic                w_commit;

    logic                r_wr_ack;
    logic [ADDR_W-1:0]   r_last_waddr;
    logic [WIDTH-1:0]    r_last_wdata;
    logic [CNT_W-1:0]    r_wr_count;

    dec5_32 u_dec (
        .i_en     (i_we),
        .i_addr   (i_waddr),
        .o_onehot (w_onehot)
    );

    // A write commits when some enable fires and it is not the r0 enable.
    assign w_commit = (|w_onehot) && !w_onehot[0];

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
        if (k == 0) begin : g_zero
            assign o_regs[0 +: WIDTH] = '0;
        end else begin : g_flop
            localparam logic [WIDTH-1:0] RST_VAL =
                (ADDR_W'(k) == REG_SP) ? SP_INIT :
                (ADDR_W'(k) == REG_GP) ? GP_INIT : '0;

            logic [WIDTH-1:0] r_q;

            always_ff @(posedge i_clk) begin
                if (i_reset) begin
                    r_q <= RST_VAL;
                end else if (w_onehot[k]) begin
                    r_q <= i_wdata;
                end
            end

            assign o_regs[k*WIDTH +: WIDTH] = r_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ack     <= 1'b0;
            r_last_waddr <= '0;
            r_last_wdata <= '0;
            r_wr_count   <= '0;
        end else if (w_commit) begin
            r_wr_ack     <= 1'b1;
            r_last_waddr <= i_waddr;
            r_last_wdata <= i_wdata;
            r_wr_count   <= r_wr_count + CNT_W'(1);
        end else begin
            r_wr_ack     <= 1'b0;
        end
    end

    assign o_wr_ack     = r_wr_ack;
    assign o_last_waddr = r_last_waddr;
    assign o_last_wdata = r_last_wdata;
    assign o_wr_count   = r_wr_count;

endmodule

// File: tb/tb_reg_write_bank.sv
// Scoreboard bench for reg_write_bank: each driven cycle pushes the expected commit record,
// which is popped and compared after the clock edge; register contents are scanned at test points.
module tb_reg_write_bank;

    localparam int unsigned W  = 32;
    localparam int unsigned NR = 32;
    localparam logic [W-1:0] SP_V = 32'h0000_03FC;
    localparam logic [W-1:0] GP_V = 32'h0000_0000;

    typedef struct packed {
        logic        ack;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [15:0] count;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              we;
    logic [4:0]        waddr;
    logic [W-1:0]      wdata;
    logic [NR*W-1:0]   regs;
    logic              wr_ack;
    logic [4:0]        last_waddr;
    logic [W-1:0]      last_wdata;
    logic [15:0]       wr_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    exp_t        sb_q[$];
    logic [31:0] m_regs [NR];
    exp_t        m_rec;

    reg_write_bank #(.WIDTH(W), .SP_INIT(SP_V), .GP_INIT(GP_V)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_we         (we),
        .i_waddr      (waddr),
        .i_wdata      (wdata),
        .o_regs       (regs),
        .o_wr_ack     (wr_ack),
        .o_last_waddr (last_waddr),
        .o_last_wdata (last_wdata),
        .o_wr_count   (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_reg(input int k);
        return regs[k*W +: W];
    endfunction

    // One clock cycle: drive, advance the model, push expectation, pop and compare after the edge.
    task automatic step(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        @(negedge clk);
        rst = r; we = w; waddr = a; wdata = d;
        if (r) begin
            for (int k = 0; k < NR; k++) m_regs[k] = 32'h0;
            m_regs[28] = GP_V;
            m_regs[29] = SP_V;
            m_rec = '0;
        end else if (w && a != 5'd0) begin
            m_regs[a]   = d;
            m_rec.ack   = 1'b1;
            m_rec.waddr = a;
            m_rec.wdata = d;
            m_rec.count = m_rec.count + 16'd1;
        end else begin
            m_rec.ack = 1'b0;
        end
        sb_q.push_back(m_rec);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("wr_ack",     32'(wr_ack),     32'(e.ack));
        check("last_waddr", 32'(last_waddr), 32'(e.waddr));
        check("last_wdata", last_wdata,      e.wdata);
        check("wr_count",   32'(wr_count),   32'(e.count));
    endtask

    task automatic scan_regs(input string tag);
        for (int k = 0; k < NR; k++) begin
            check($sformatf("%s_r%0d", tag, k), dut_reg(k), m_regs[k]);
        end
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        for (int k = 0; k < NR; k++) m_regs[k] = 32'h0;
        m_rec = '0;

        // Reset for two cycles
        step(1'b1, 1'b0, 5'd0, 32'h0);
        step(1'b1, 1'b0, 5'd0, 32'h0);
        scan_regs("reset");
        check("reset_sp", dut_reg(29), 32'h0000_03FC);
        check("reset_gp", dut_reg(28), 32'h0000_0000);

        // Single write then idle: ack is a one-cycle pulse
        step(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        check("single_r5", dut_reg(5), 32'hDEAD_BEEF);
        check("single_cnt", 32'(wr_count), 32'd1);
        step(1'b0, 1'b0, 5'd5, 32'h0);
        check("single_ack_drop", 32'(wr_ack), 32'd0);
        scan_regs("single");

        // r0 protection
        step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        check("r0_zero", dut_reg(0), 32'h0);
        check("r0_cnt", 32'(wr_count), 32'd1);

        // Disabled writes, including unknown address/data
        step(1'b0, 1'b0, 5'd7, 32'h1234_5678);
        step(1'b0, 1'b0, 5'bx, 32'hxxxx_xxxx);
        check("dis_r7", dut_reg(7), 32'h0);
        scan_regs("disabled");

        // Burst k <- 3k, then two colliding writes to r31
        for (int k = 1; k < NR; k++) step(1'b0, 1'b1, 5'(k), 32'(3 * k));
        step(1'b0, 1'b1, 5'd31, 32'hA5A5_A5A5);
        step(1'b0, 1'b1, 5'd31, 32'hA5A5_A5A5);
        for (int k = 1; k < NR - 1; k++) check($sformatf("burst_r%0d", k), dut_reg(k), 32'(3 * k));
        check("burst_r31", dut_reg(31), 32'hA5A5_A5A5);
        check("burst_cnt", 32'(wr_count), 32'd34);
        scan_regs("burst");

        // Reset wins over a same-edge write
        step(1'b1, 1'b1, 5'd29, 32'h0);
        check("rst_vs_wr_sp", dut_reg(29), 32'h0000_03FC);
        check("rst_vs_wr_cnt", 32'(wr_count), 32'd0);
        scan_regs("rst_vs_wr");

        // Preload counter to 16'hFFFF, then one more write wraps it
        for (int i = 0; i < 65535; i++) step(1'b0, 1'b1, 5'((i % 31) + 1), 32'(i));
        check("cnt_full", 32'(wr_count), 32'h0000_FFFF);
        step(1'b0, 1'b1, 5'd3, 32'hCAFE_F00D);
        check("cnt_wrap", 32'(wr_count), 32'd0);
        check("wrap_r3", dut_reg(3), 32'hCAFE_F00D);
        scan_regs("wrap");

        // Mid-sequence reset clears registers and record
        step(1'b0, 1'b1, 5'd12, 32'h0BAD_F00D);
        step(1'b1, 1'b0, 5'd0, 32'h0);
        check("midrst_r12", dut_reg(12), 32'h0);
        scan_regs("midrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
